mux32_to_1: RTL and testbench



---
 rtl/mux32_to_1_if.sv | 12 +
 rtl/mux32_to_1.sv | 96 +++++++++
 tb/tb_mux32_to_1.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mux32_to_1_if.sv
// Bundle of select/data/result signals for the registered 32-to-1 word mux.
// The master drives addr and the data words; the slave returns the registered word.
interface mux32_to_1_if #(
    parameter int unsigned WIDTH = 32
);
    logic [4:0]       addr;
    logic [WIDTH-1:0] din [32];
    logic [WIDTH-1:0] muxout;

    modport master (output addr, output din, input muxout);
    modport slave  (input addr, input din, output muxout);
endinterface

// File: rtl/mux32_to_1.sv
// Registered 32-to-1 word multiplexer: muxout takes din[addr] one clock after sampling.
// Asynchronous active-low reset clears the output register.
module mux32_to_1 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       addr,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic [WIDTH-1:0] din4,
    input  logic [WIDTH-1:0] din5,
    input  logic [WIDTH-1:0] din6,
    input  logic [WIDTH-1:0] din7,
    input  logic [WIDTH-1:0] din8,
    input  logic [WIDTH-1:0] din9,
    input  logic [WIDTH-1:0] din10,
    input  logic [WIDTH-1:0] din11,
    input  logic [WIDTH-1:0] din12,
    input  logic [WIDTH-1:0] din13,
    input  logic [WIDTH-1:0] din14,
    input  logic [WIDTH-1:0] din15,
    input  logic [WIDTH-1:0] din16,
    input  logic [WIDTH-1:0] din17,
    input  logic [WIDTH-1:0] din18,
    input  logic [WIDTH-1:0] din19,
    input  logic [WIDTH-1:0] din20,
    input  logic [WIDTH-1:0] din21,
    input  logic [WIDTH-1:0] din22,
    input  logic [WIDTH-1:0] din23,
    input  logic [WIDTH-1:0] din24,
    input  logic [WIDTH-1:0] din25,
    input  logic [WIDTH-1:0] din26,
    input  logic [WIDTH-1:0] din27,
    input  logic [WIDTH-1:0] din28,
    input  logic [WIDTH-1:0] din29,
    input  logic [WIDTH-1:0] din30,
    input  logic [WIDTH-1:0] din31,
    output logic [WIDTH-1:0] muxout
);

    // Flat ports gathered into an array so the select is a single index.
    logic [WIDTH-1:0] din_w [32];
    logic [WIDTH-1:0] muxout_d;
    logic [WIDTH-1:0] muxout_q;

    assign din_w[0]  = din0;
    assign din_w[1]  = din1;
    assign din_w[2]  = din2;
    assign din_w[3]  = din3;
    assign din_w[4]  = din4;
    assign din_w[5]  = din5;
    assign din_w[6]  = din6;
    assign din_w[7]  = din7;
    assign din_w[8]  = din8;
    assign din_w[9]  = din9;
    assign din_w[10] = din10;
    assign din_w[11] = din11;
    assign din_w[12] = din12;
    assign din_w[13] = din13;
    assign din_w[14] = din14;
    assign din_w[15] = din15;
    assign din_w[16] = din16;
    assign din_w[17] = din17;
    assign din_w[18] = din18;
    assign din_w[19] = din19;
    assign din_w[20] = din20;
    assign din_w[21] = din21;
    assign din_w[22] = din22;
    assign din_w[23] = din23;
    assign din_w[24] = din24;
    assign din_w[25] = din25;
    assign din_w[26] = din26;
    assign din_w[27] = din27;
    assign din_w[28] = din28;
    assign din_w[29] = din29;
    assign din_w[30] = din30;
    assign din_w[31] = din31;

    always_comb begin
        muxout_d = din_w[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            muxout_q <= '0;
        end else begin
            muxout_q <= muxout_d;
        end
    end

    assign muxout = muxout_q;

endmodule

// File: tb/tb_mux32_to_1.sv
// Self-checking bench for mux32_to_1: per-cycle model comparison plus directed literal checks.
module tb_mux32_to_1;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic compare_en;
    logic [WIDTH-1:0] exp_q;

    mux32_to_1_if #(.WIDTH(WIDTH)) bus ();

    mux32_to_1 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr(bus.addr),
        .din0(bus.din[0]),   .din1(bus.din[1]),   .din2(bus.din[2]),   .din3(bus.din[3]),
        .din4(bus.din[4]),   .din5(bus.din[5]),   .din6(bus.din[6]),   .din7(bus.din[7]),
        .din8(bus.din[8]),   .din9(bus.din[9]),   .din10(bus.din[10]), .din11(bus.din[11]),
        .din12(bus.din[12]), .din13(bus.din[13]), .din14(bus.din[14]), .din15(bus.din[15]),
        .din16(bus.din[16]), .din17(bus.din[17]), .din18(bus.din[18]), .din19(bus.din[19]),
        .din20(bus.din[20]), .din21(bus.din[21]), .din22(bus.din[22]), .din23(bus.din[23]),
        .din24(bus.din[24]), .din25(bus.din[25]), .din26(bus.din[26]), .din27(bus.din[27]),
        .din28(bus.din[28]), .din29(bus.din[29]), .din30(bus.din[30]), .din31(bus.din[31]),
        .muxout(bus.muxout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the word chosen at the last sampling edge, or zero while reset is held.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q = '0;
        else        exp_q = bus.din[bus.addr];
    end

    always @(negedge clk) begin
        if (compare_en) begin
            checks++;
            if (bus.muxout !== exp_q)
                $display("FAIL model_cmp t=%0t muxout=%h expected=%h", $time, bus.muxout, exp_q);
            else if (bus.muxout !== exp_q) failures++;
            if (bus.muxout !== exp_q) failures++;
        end
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        compare_en = 1'b0;
        rst_n = 1'b1;
        bus.addr = 5'd0;
        for (int i = 0; i < 32; i++) bus.din[i] = '0;
        bus.din[0] = 32'd30;

        // Reset asserts between edges; output must clear without a clock edge.
        #1 rst_n = 1'b0;
        #1 check("reset_async", bus.muxout, 32'd0);
        compare_en = 1'b1;
        repeat (3) edge_settle();
        check("reset_hold", bus.muxout, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1 check("release_pre_edge", bus.muxout, 32'd0);
        edge_settle();
        check("release_first_load", bus.muxout, 32'd30);

        // Basic select
        @(negedge clk);
        bus.din[1] = 32'd10;
        bus.din[20] = 32'd24;
        bus.addr = 5'd20;
        #1 check("select_before_edge", bus.muxout, 32'd30);
        edge_settle();
        check("select_addr20", bus.muxout, 32'd24);

        // Address sweep across the full decode range
        @(negedge clk);
        for (int i = 0; i < 32; i++) bus.din[i] = 32'hA000_0000 + i;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            bus.addr = a[4:0];
            edge_settle();
            check("sweep", bus.muxout, 32'hA000_0000 + a);
        end
        check("sweep_addr31", bus.muxout, 32'hA000_001F);

        // Data-only change at a fixed address
        @(negedge clk);
        bus.addr = 5'd5;
        bus.din[5] = 32'd14;
        edge_settle();
        check("data_hold_14", bus.muxout, 32'd14);
        @(negedge clk);
        bus.din[5] = 32'hFFFF_FFFF;
        #1 check("data_mid_cycle", bus.muxout, 32'd14);
        edge_settle();
        check("data_new_value", bus.muxout, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.din[6] = 32'h1234_5678;
        edge_settle();
        check("unselected_change", bus.muxout, 32'hFFFF_FFFF);

        // Asynchronous reset pulse mid-run
        @(negedge clk);
        bus.addr = 5'd20;
        bus.din[20] = 32'd24;
        edge_settle();
        check("pre_reset_value", bus.muxout, 32'd24);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("midrun_async_clear", bus.muxout, 32'd0);
        #1 rst_n = 1'b1;
        #1 check("after_release_no_edge", bus.muxout, 32'd0);
        edge_settle();
        check("reload_after_reset", bus.muxout, 32'd24);

        // Full-width propagation
        @(negedge clk);
        bus.din[12] = 32'h8000_0001;
        bus.addr = 5'd12;
        edge_settle();
        check("full_width", bus.muxout, 32'h8000_0001);

        // Simultaneous address and data change
        @(negedge clk);
        bus.addr = 5'd31;
        bus.din[31] = 32'h5A5A_C3C3;
        edge_settle();
        check("addr_data_together", bus.muxout, 32'h5A5A_C3C3);

        @(negedge clk);
        compare_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout t=%0t got=stalled expected=finish", $time);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
